bcd_count_sequencer: RTL and testbench
======================================

# bcd_count_sequencer

Run/stop/clear controller for the four-digit decimal counter chain. It debounces the front-panel buttons, runs a small state machine, and turns each slow-clock tick into per-digit enable and clear pulses for four 4-bit digit counters, with decimal carry between them. It sits between the clock divider's tick and the digit counters; the counter values feed back into it to form the carries.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 50000: consecutive stable synchronized samples required to accept a button press or release (≥2).

Ports:
- clk  input  1  system clock; every flop in the block runs on it.
- rst_n  input  1  asynchronous, active-low reset.
- tick  input  1  one-cycle count strobe from the divider; consecutive ticks are ≥2 cycles apart.
- btn_run_n  input  1  run/stop button, asynchronous, pressed = 0.
- btn_clr_n  input  1  clear button, asynchronous, pressed = 0.
- q0, q1, q2, q3  input  4 each  current digit values; q0 is the least significant digit.
- ena  output  4  per-digit increment pulse; bit i drives digit i.
- clr  output  4  per-digit synchronous clear pulse; bit i drives digit i.
- running  output  1  high while in RUN.
- overflow  output  1  terminal-count indicator.

Digit counter contract: on each clk edge a digit counter loads 0 if its clr bit is 1, otherwise loads q+1 if its ena bit is 1, otherwise holds.

## Operation
- Button path, per button:
  - 2-flop synchronizer, reset to the released level 1.
  - Stability counter. A press pulse of exactly one cycle fires once the synchronized level has been 0 for DEBOUNCE_CYCLES consecutive cycles.
  - The detector re-arms only after the level has been 1 for DEBOUNCE_CYCLES cycles. Holding the button never repeats the pulse.
  - Glitches shorter than DEBOUNCE_CYCLES produce nothing.
- States: IDLE, RUN, CLEAR, DONE. Reset state is IDLE.
  - IDLE: on a run pulse, go to RUN.
  - RUN: on a run pulse, go to IDLE. On tick, issue the count pulses described below.
  - CLEAR: lasts exactly one cycle with clr=4'b1111 and ena=0, then goes to IDLE. Overflow clears on entry to CLEAR.
  - DONE: holds the count. A run pulse is ignored here.
  - A clear pulse sends every state to CLEAR.
  - A clear pulse and a run pulse in the same cycle: clear wins and the run pulse is discarded.
  - ena and clr are 0 in every state and cycle not listed above.
- Count pulses, generated only in RUN when tick=1:
  - carry0=1; carry(i+1) = carry(i) AND (q(i) ≥ 9).
  - ena(i) = carry(i) AND (q(i) < 9).
  - clr(i) = carry(i) AND (q(i) ≥ 9).
  - An illegal digit value of 10–15 is treated as a rollover, so it clears to 0. No digit ever counts past 9.
- Terminal count is q3..q0 = 9999 on a tick in RUN. The behaviour here depends on SATURATE_EN (see Configuration).
- A tick arriving outside RUN is dropped and is not queued.

## Timing
- ena, clr, running and overflow are all registered.
- Tick sampled high in cycle n → ena/clr high for exactly cycle n+1 → the counter shows the new value in cycle n+2.
- Button edge to command pulse: 2 synchronizer cycles + DEBOUNCE_CYCLES, ±1 cycle. The state changes on the cycle after the pulse.
- running tracks the registered state and goes high on the cycle after the IDLE→RUN transition.
- Reset asserted mid-operation: asynchronously forces IDLE, ena=0, clr=0, running=0, overflow=0, and debouncers released with counters at 0. Any in-flight pulse is lost.
- After rst_n deasserts, nothing happens until a button is accepted. Digit values are left as they were; the block does not clear them.

## Configuration
SATURATE_EN:
- Defined: at terminal count the block issues no ena/clr, moves RUN→DONE, and sets overflow high. overflow stays high until CLEAR or reset. The display holds 9999.
- Undefined: at terminal count clr=4'b1111 for one cycle and overflow pulses high in that same cycle. The state stays RUN, the count wraps to 0000, and DONE is unreachable.

## Test plan
Bench settings: DEBOUNCE_CYCLES=4, tick every 3 cycles, behavioural digit counters.
1. Reset, then press run for 10 cycles → one run pulse, running=1. After 12 ticks the digits read 0012. A held button never produces a second pulse.
2. Digits preset to 0099, in RUN, one tick → ena=4'b0100, clr=4'b0011 for one cycle → digits read 0100.
3. Digits preset to 9999, in RUN, one tick:
   - SATURATE_EN defined → no pulses, state DONE, overflow=1, and later ticks leave 9999 unchanged.
   - SATURATE_EN undefined → clr=4'b1111, one-cycle overflow pulse, digits read 0000, running stays 1.
4. Press clear and run with simultaneous accepted pulses while in RUN at 0347 → CLEAR for one cycle with clr=4'b1111, then IDLE, digits read 0000, running=0.
5. 3-cycle low glitch on btn_run_n → no state change. Digit q1=4'b1100 injected in RUN, tick with q0=9 → clr(0)=1 and clr(1)=1, ena(2)=1.
6. rst_n asserted low on the same cycle as an ena pulse → ena drops to 0 immediately, state IDLE, overflow=0.

Source files
------------

// File: rtl/bcd_count_sequencer.sv
// bcd_count_sequencer: run/stop/clear controller for a four-digit BCD counter
// chain. Debounces the run and clear buttons, runs an IDLE/RUN/CLEAR/DONE
// state machine and turns each divider tick into per-digit ena/clr pulses
// with decimal carry.
// Build option: define SATURATE_EN to hold at 9999 (enter DONE, latch
// overflow). Without it the count wraps to 0000 with a one-cycle overflow.
module bcd_count_sequencer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       btn_run_n,
  input  logic       btn_clr_n,
  input  logic [3:0] q0,
  input  logic [3:0] q1,
  input  logic [3:0] q2,
  input  logic [3:0] q3,
  output logic [3:0] ena,
  output logic [3:0] clr,
  output logic       running,
  output logic       overflow
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CLEAR = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Button index 0 is run, index 1 is clear.
  logic [1:0] w_btn_n;
  logic [1:0] w_pulse;

  assign w_btn_n = {btn_clr_n, btn_run_n};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic [1:0]    r_sync;
      logic          r_level;
      logic [CW-1:0] r_cnt;
      logic          r_pulse;

      // Two-flop synchronizer, idling at the released level.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync <= 2'b11;
        end else begin
          r_sync <= {r_sync[0], w_btn_n[gi]};
        end
      end

      // Accept a new level only after it has been stable for the full window;
      // a single pulse marks each accepted press.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_level <= 1'b1;
          r_cnt   <= '0;
          r_pulse <= 1'b0;
        end else begin
          r_pulse <= 1'b0;
          if (r_sync[1] == r_level) begin
            r_cnt <= '0;
          end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_level <= r_sync[1];
            r_cnt   <= '0;
            r_pulse <= ~r_sync[1];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign w_pulse[gi] = r_pulse;
    end
  endgenerate

  logic w_run_pulse;
  logic w_clr_pulse;

  assign w_run_pulse = w_pulse[0];
  assign w_clr_pulse = w_pulse[1];

  // Decimal carry chain. Any digit at 9 or above (including illegal 10-15)
  // rolls over to 0 and passes the carry up.
  logic [3:0] w_q [4];
  logic [3:0] w_ge9;
  logic [3:0] w_carry;
  logic [3:0] w_cnt_ena;
  logic [3:0] w_cnt_clr;
  logic       w_terminal;

  assign w_q[0] = q0;
  assign w_q[1] = q1;
  assign w_q[2] = q2;
  assign w_q[3] = q3;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      assign w_ge9[gi] = (w_q[gi] >= 4'd9);
      if (gi == 0) begin : g_first
        assign w_carry[gi] = 1'b1;
      end else begin : g_rest
        assign w_carry[gi] = &w_ge9[gi-1:0];
      end
      assign w_cnt_ena[gi] = w_carry[gi] & ~w_ge9[gi];
      assign w_cnt_clr[gi] = w_carry[gi] &  w_ge9[gi];
    end
  endgenerate

  assign w_terminal = (q0 == 4'd9) && (q1 == 4'd9) && (q2 == 4'd9) && (q3 == 4'd9);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_ena;
  logic [3:0] r_clr;
  logic       r_running;
  logic       r_overflow;
  logic [3:0] w_ena_next;
  logic [3:0] w_clr_next;
  logic       w_ovf_next;

  // Next state and next registered outputs; clear has priority over run.
  always_comb begin
    w_state_next = r_state;
    w_ena_next   = 4'b0000;
    w_clr_next   = 4'b0000;
`ifdef SATURATE_EN
    w_ovf_next   = r_overflow;
`else
    w_ovf_next   = 1'b0;
`endif
    if (w_clr_pulse) begin
      w_state_next = S_CLEAR;
      w_clr_next   = 4'b1111;
      w_ovf_next   = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_run_pulse) w_state_next = S_RUN;
        end
        S_RUN: begin
          if (tick) begin
`ifdef SATURATE_EN
            if (w_terminal) begin
              w_state_next = S_DONE;
              w_ovf_next   = 1'b1;
            end else begin
              w_ena_next = w_cnt_ena;
              w_clr_next = w_cnt_clr;
            end
`else
            w_ena_next = w_cnt_ena;
            w_clr_next = w_cnt_clr;
            w_ovf_next = w_terminal;
`endif
          end
          if (w_run_pulse) w_state_next = S_IDLE;
        end
        S_CLEAR: begin
          w_state_next = S_IDLE;
        end
        S_DONE: begin
          w_state_next = S_DONE;
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ena      <= 4'b0000;
      r_clr      <= 4'b0000;
      r_running  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_ena      <= w_ena_next;
      r_clr      <= w_clr_next;
      r_running  <= (w_state_next == S_RUN);
      r_overflow <= w_ovf_next;
    end
  end

  assign ena      = r_ena;
  assign clr      = r_clr;
  assign running  = r_running;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_bcd_count_sequencer.sv
// Directed bench for bcd_count_sequencer with behavioural digit counters.
// Honours SATURATE_EN for the terminal-count scenario.
module tb_bcd_count_sequencer;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       btn_run_n;
  logic       btn_clr_n;
  logic [3:0] q0, q1, q2, q3;
  logic [3:0] ena;
  logic [3:0] clr;
  logic       running;
  logic       overflow;

  logic        preset_req;
  logic [15:0] preset_val;
  logic [15:0] digits;

  int n_checks = 0;
  int n_errors = 0;

  bcd_count_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .btn_run_n (btn_run_n),
    .btn_clr_n (btn_clr_n),
    .q0        (q0),
    .q1        (q1),
    .q2        (q2),
    .q3        (q3),
    .ena       (ena),
    .clr       (clr),
    .running   (running),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign digits = {q3, q2, q1, q0};

  // Behavioural digit counters following the clr/ena contract, plus preset.
  always @(posedge clk) begin
    if (preset_req) begin
      {q3, q2, q1, q0} <= preset_val;
    end else begin
      q0 <= clr[0] ? 4'd0 : (ena[0] ? q0 + 4'd1 : q0);
      q1 <= clr[1] ? 4'd0 : (ena[1] ? q1 + 4'd1 : q1);
      q2 <= clr[2] ? 4'd0 : (ena[2] ? q2 + 4'd1 : q2);
      q3 <= clr[3] ? 4'd0 : (ena[3] ? q3 + 4'd1 : q3);
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end else begin
      $display("check %s observed %h ok", tag, obs);
    end
  endtask

  task automatic preset(input logic [15:0] v);
    @(negedge clk);
    preset_req = 1'b1;
    preset_val = v;
    @(negedge clk);
    preset_req = 1'b0;
  endtask

  task automatic press(input logic do_run, input logic do_clr, input int hold);
    @(negedge clk);
    if (do_run) btn_run_n = 1'b0;
    if (do_clr) btn_clr_n = 1'b0;
    repeat (hold) @(negedge clk);
    btn_run_n = 1'b1;
    btn_clr_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // Returns at the negedge of the cycle where ena/clr respond to the tick.
  task automatic tick_once();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic auto_ticks(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      tick = ((i % 3) == 0);
    end
    @(negedge clk);
    tick = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_clr_cycles;
    rst_n      = 1'b0;
    tick       = 1'b0;
    btn_run_n  = 1'b1;
    btn_clr_n  = 1'b1;
    preset_req = 1'b0;
    preset_val = 16'h0000;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_ena", {12'h0, ena}, 16'h0);
    chk("reset_clr", {12'h0, clr}, 16'h0);
    chk("reset_running", {15'h0, running}, 16'h0);
    chk("reset_overflow", {15'h0, overflow}, 16'h0);
    rst_n = 1'b1;
    preset(16'h0000);

    // 1: held run button gives one pulse; 12 ticks count to 0012
    press(1'b1, 1'b0, 10);
    chk("t1_running", {15'h0, running}, 16'h1);
    auto_ticks(36);
    repeat (3) @(negedge clk);
    chk("t1_digits", digits, 16'h0012);
    chk("t1_still_running", {15'h0, running}, 16'h1);

    // 2: 0099 + 1 -> 0100
    preset(16'h0099);
    tick_once();
    chk("t2_ena", {12'h0, ena}, 16'h0004);
    chk("t2_clr", {12'h0, clr}, 16'h0003);
    @(negedge clk);
    chk("t2_ena_gone", {12'h0, ena}, 16'h0);
    chk("t2_digits", digits, 16'h0100);

    // 3: terminal count
    preset(16'h9999);
    tick_once();
`ifdef SATURATE_EN
    chk("t3_ena", {12'h0, ena}, 16'h0);
    chk("t3_clr", {12'h0, clr}, 16'h0);
    chk("t3_overflow", {15'h0, overflow}, 16'h1);
    chk("t3_running", {15'h0, running}, 16'h0);
    tick_once();
    tick_once();
    @(negedge clk);
    chk("t3_hold_digits", digits, 16'h9999);
    chk("t3_hold_overflow", {15'h0, overflow}, 16'h1);
    press(1'b1, 1'b0, 8);
    chk("t3_run_ignored", {15'h0, running}, 16'h0);
    press(1'b0, 1'b1, 8);
    chk("t3_clear_overflow", {15'h0, overflow}, 16'h0);
    chk("t3_clear_digits", digits, 16'h0000);
    press(1'b1, 1'b0, 8);
    chk("t3_rerun", {15'h0, running}, 16'h1);
`else
    chk("t3_ena", {12'h0, ena}, 16'h0);
    chk("t3_clr", {12'h0, clr}, 16'h000F);
    chk("t3_overflow", {15'h0, overflow}, 16'h1);
    @(negedge clk);
    chk("t3_overflow_pulse", {15'h0, overflow}, 16'h0);
    chk("t3_digits", digits, 16'h0000);
    chk("t3_running", {15'h0, running}, 16'h1);
`endif

    // 4: simultaneous clear and run at 0347 -> CLEAR then IDLE
    preset(16'h0347);
    n_clr_cycles = 0;
    @(negedge clk);
    btn_run_n = 1'b0;
    btn_clr_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 8) begin
        btn_run_n = 1'b1;
        btn_clr_n = 1'b1;
      end
      if (clr == 4'b1111) n_clr_cycles++;
    end
    chk("t4_clr_cycles", 16'(n_clr_cycles), 16'd1);
    chk("t4_digits", digits, 16'h0000);
    chk("t4_running", {15'h0, running}, 16'h0);

    // 5: short glitch ignored; illegal digit rolls over
    @(negedge clk);
    btn_run_n = 1'b0;
    repeat (3) @(negedge clk);
    btn_run_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("t5_glitch", {15'h0, running}, 16'h0);
    press(1'b1, 1'b0, 8);
    chk("t5_run", {15'h0, running}, 16'h1);
    preset(16'h00C9);
    tick_once();
    chk("t5_ena", {12'h0, ena}, 16'h0004);
    chk("t5_clr", {12'h0, clr}, 16'h0003);
    @(negedge clk);
    chk("t5_digits", digits, 16'h0100);

    // 6: reset during an ena pulse
    preset(16'h0005);
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    chk("t6_ena_before", {12'h0, ena}, 16'h0001);
    rst_n = 1'b0;
    #1;
    chk("t6_ena", {12'h0, ena}, 16'h0);
    chk("t6_clr", {12'h0, clr}, 16'h0);
    chk("t6_running", {15'h0, running}, 16'h0);
    chk("t6_overflow", {15'h0, overflow}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_digits", digits, 16'h0005);
    chk("t6_idle", {15'h0, running}, 16'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
